// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone master bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h06;
  localparam logic [7:0] RSP_ERR   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/uart_wb_bridge_if.sv
// UART byte streams and Wishbone classic master signals of the bridge.
interface uart_wb_bridge_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, wbm_dat_i, wbm_ack_i,
    output rx_ready, tx_data, tx_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wbm_dat_i, wbm_ack_i,
    input  rx_ready, tx_data, tx_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
  );

endinterface

// File: rtl/bridge_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
module bridge_timer #(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned W = $clog2(LOAD_VAL);

  logic [W-1:0] count;

  // Loading LOAD_VAL-1 makes expiry coincide with the LOAD_VAL-th edge after the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL - 1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_wb_bridge.sv
// Wishbone classic master driven by command frames from a UART byte stream.
module uart_wb_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT  = 100000
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  uart_wb_bridge_if.master bus
);

  state_t      state;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [1:0]  tx_left;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [23:0] rsp_tail;
  logic        cyc;
  logic        we;
  logic [7:0]  tx_data;
  logic        tx_valid;

  logic        rx_ready;
  logic        rx_accept;
  logic        tx_done;
  logic        in_frame;
  logic        rx_load;
  logic        bus_load;
  logic        rx_expired;
  logic        bus_expired;

  assign in_frame  = (state == ADDR) || (state == DATA);
  assign rx_ready  = ~wb_rst_i & ((state == IDLE) | in_frame);
  assign rx_accept = bus.rx_valid & rx_ready;
  assign tx_done   = tx_valid & bus.tx_ready;
  assign rx_load   = rx_accept | ~in_frame;
  assign bus_load  = (state != BUS);

  bridge_timer #(.LOAD_VAL(RX_TIMEOUT)) u_rx_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (rx_load),
    .expired (rx_expired)
  );

  bridge_timer #(.LOAD_VAL(BUS_TIMEOUT)) u_bus_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (bus_load),
    .expired (bus_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
      tx_left  <= '0;
      adr      <= '0;
      dat      <= '0;
      rsp_tail <= '0;
      cyc      <= 1'b0;
      we       <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_accept && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
            is_write <= (bus.rx_data == CMD_WRITE);
            byte_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          // An accepted byte takes precedence over a simultaneous inter-byte timeout.
          if (rx_accept) begin
            adr      <= {adr[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= DATA;
              end else begin
                state <= BUS;
                cyc   <= 1'b1;
                we    <= 1'b0;
              end
            end
          end else if (rx_expired) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rx_accept) begin
            dat      <= {dat[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= BUS;
              cyc   <= 1'b1;
              we    <= 1'b1;
            end
          end else if (rx_expired) begin
            state <= IDLE;
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            cyc      <= 1'b0;
            we       <= 1'b0;
            tx_valid <= 1'b1;
            state    <= RESP;
            if (is_write) begin
              tx_data <= RSP_OK;
              tx_left <= '0;
            end else begin
              tx_data  <= bus.wbm_dat_i[31:24];
              rsp_tail <= bus.wbm_dat_i[23:0];
              tx_left  <= 2'd3;
            end
          end else if (bus_expired) begin
            cyc      <= 1'b0;
            we       <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= RSP_ERR;
            tx_left  <= '0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (tx_done) begin
            if (tx_left == '0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data  <= rsp_tail[23:16];
              rsp_tail <= {rsp_tail[15:0], 8'h00};
              tx_left  <= tx_left - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;
  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = cyc;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_sel_o = {4{cyc}};
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge with a Wishbone slave model and a UART tx sink.
module tb_uart_wb_bridge;

  localparam int unsigned BT = 16;
  localparam int unsigned RT = 40;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_tx[$];
  int          slave_delay = 0;
  logic [31:0] slave_rdata = '0;
  int          tx_stall = 0;

  int          stb_n = 0;
  bus_exp_t    cur;
  logic        have_cur = 1'b0;
  logic        in_byte = 1'b0;
  logic [7:0]  held = '0;
  int          wait_n = 0;

  uart_wb_bridge_if bus_if();

  uart_wb_bridge #(
    .BUS_TIMEOUT (BT),
    .RX_TIMEOUT  (RT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // Wishbone slave model and UART tx sink, both acting on the falling edge.
  always @(negedge clk) begin
    bus_if.tx_ready = 1'b0;
    if (rst) begin
      stb_n            = 0;
      have_cur         = 1'b0;
      in_byte          = 1'b0;
      bus_if.wbm_ack_i = 1'b0;
      bus_if.wbm_dat_i = '0;
    end else begin
      if (bus_if.wbm_stb_o) begin
        stb_n++;
        if (stb_n == 1) begin
          check("wb_expected", 32'(exp_bus.size() != 0), 1);
          have_cur = (exp_bus.size() != 0);
          if (have_cur) begin
            cur = exp_bus.pop_front();
            check("wb_adr", bus_if.wbm_adr_o, cur.adr);
            check("wb_we", 32'(bus_if.wbm_we_o), 32'(cur.we));
            check("wb_sel", 32'(bus_if.wbm_sel_o), 32'h0000_000F);
            if (cur.we) check("wb_dat", bus_if.wbm_dat_o, cur.dat);
          end
        end
        check("wb_cyc", 32'(bus_if.wbm_cyc_o), 1);
        bus_if.wbm_ack_i = (slave_delay >= 0) && (stb_n == slave_delay + 1);
        bus_if.wbm_dat_i = slave_rdata;
      end else begin
        if (stb_n > 0 && have_cur) check("wb_stb_len", 32'(stb_n), 32'(cur.len));
        stb_n            = 0;
        have_cur         = 1'b0;
        bus_if.wbm_ack_i = 1'b0;
        bus_if.wbm_dat_i = ~slave_rdata;
      end

      if (bus_if.tx_valid) begin
        if (!in_byte) begin
          in_byte = 1'b1;
          held    = bus_if.tx_data;
          wait_n  = 0;
          check("tx_expected", 32'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) check("tx_byte", 32'(bus_if.tx_data), 32'(exp_tx.pop_front()));
        end else begin
          check("tx_stable", 32'(bus_if.tx_data), 32'(held));
        end
        if (wait_n >= tx_stall) begin
          bus_if.tx_ready = 1'b1;
          in_byte         = 1'b0;
        end else begin
          wait_n++;
        end
      end else begin
        in_byte = 1'b0;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int unsigned g = 0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (!bus_if.rx_ready && g < 4 * BT + 200) begin
      @(negedge clk);
      g++;
    end
    check("rx_ready_wait", 32'(bus_if.rx_ready), 1);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(we ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
    if (we) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int unsigned g = 0;
    while ((bus_if.busy || exp_tx.size() != 0) && g < 4 * BT + 400) begin
      @(negedge clk);
      g++;
    end
    check("idle_busy", 32'(bus_if.busy), 0);
    check("tx_drained", 32'(exp_tx.size()), 0);
    check("wb_drained", 32'(exp_bus.size()), 0);
  endtask

  task automatic expect_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int delay);
    bus_exp_t e;
    logic     timed_out;
    timed_out = (delay < 0) || (delay >= int'(BT));
    e.adr = adr;
    e.dat = dat;
    e.we  = we;
    e.len = timed_out ? int'(BT) : delay + 1;
    slave_delay = delay;
    exp_bus.push_back(e);
    if (timed_out) exp_tx.push_back(8'h15);
    else if (we) exp_tx.push_back(8'h06);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(slave_rdata[8*i +: 8]);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int delay);
    expect_txn(we, adr, dat, delay);
    send_frame(we, adr, dat);
    wait_idle();
  endtask

  initial begin
    int unsigned g;
    bus_if.rx_data  = '0;
    bus_if.rx_valid = 1'b0;

    @(negedge clk);
    check("rst_rx_ready", 32'(bus_if.rx_ready), 0);
    check("rst_cyc", 32'(bus_if.wbm_cyc_o), 0);
    check("rst_tx_valid", 32'(bus_if.tx_valid), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_sel", 32'(bus_if.wbm_sel_o), 0);
    check("rst_adr", bus_if.wbm_adr_o, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst_rx_ready", 32'(bus_if.rx_ready), 1);
    check("post_rst_busy", 32'(bus_if.busy), 0);
    @(negedge clk);

    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 2);

    tx_stall    = 5;
    slave_rdata = 32'h01C9_C380;
    run_txn(1'b0, 32'h3000_0000, 32'h0, 1);
    tx_stall    = 0;

    // Latency with immediate ack and tx_ready high.
    expect_txn(1'b1, 32'h0000_0040, 32'h1357_9BDF, 0);
    send_frame(1'b1, 32'h0000_0040, 32'h1357_9BDF);
    check("lat_stb_rise", 32'(bus_if.wbm_stb_o), 1);
    @(negedge clk);
    check("lat_tx_valid", 32'(bus_if.tx_valid), 1);
    check("lat_stb_fall", 32'(bus_if.wbm_stb_o), 0);
    @(negedge clk);
    check("lat_idle", 32'(bus_if.busy), 0);
    check("lat_rx_ready", 32'(bus_if.rx_ready), 1);
    wait_idle();

    slave_rdata = 32'h7777_7777;
    run_txn(1'b0, 32'h3000_0008, 32'h0, -1);
    run_txn(1'b1, 32'h3000_000C, 32'h1234_5678, 0);

    run_txn(1'b1, 32'h2000_0000, 32'h0BAD_F00D, int'(BT) - 1);
    slave_rdata = 32'hA5C3_0F96;
    run_txn(1'b0, 32'h2000_0004, 32'h0, int'(BT) - 1);
    run_txn(1'b0, 32'h2000_0008, 32'h0, int'(BT));

    send_byte(8'h41);
    check("junk_busy", 32'(bus_if.busy), 0);
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h00);
    repeat (RT - 1) @(negedge clk);
    check("rxto_before", 32'(bus_if.busy), 1);
    @(negedge clk);
    check("rxto_after", 32'(bus_if.busy), 0);
    check("rxto_rx_ready", 32'(bus_if.rx_ready), 1);

    // A byte landing on the expiry edge keeps the frame alive.
    expect_txn(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 0);
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h00);
    repeat (RT - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h10);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'hCAFE_F00D >> (8 * i)));
    wait_idle();

    slave_delay = -1;
    exp_bus.push_back('{adr: 32'h3000_0014, dat: 32'h5555_AAAA, we: 1'b1, len: int'(BT)});
    send_frame(1'b1, 32'h3000_0014, 32'h5555_AAAA);
    repeat (3) @(negedge clk);
    check("rst1_stb_pre", 32'(bus_if.wbm_stb_o), 1);
    #2 rst = 1'b1;
    #1;
    check("rst1_stb", 32'(bus_if.wbm_stb_o), 0);
    check("rst1_cyc", 32'(bus_if.wbm_cyc_o), 0);
    check("rst1_rx_ready", 32'(bus_if.rx_ready), 0);
    check("rst1_busy", 32'(bus_if.busy), 0);
    exp_bus.delete();
    exp_tx.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst1_rx_ready_after", 32'(bus_if.rx_ready), 1);
    @(negedge clk);

    tx_stall = 30;
    expect_txn(1'b1, 32'h3000_0018, 32'h0F0F_0F0F, 0);
    send_frame(1'b1, 32'h3000_0018, 32'h0F0F_0F0F);
    g = 0;
    while (!bus_if.tx_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("rst2_tx_valid_pre", 32'(bus_if.tx_valid), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst2_tx_valid", 32'(bus_if.tx_valid), 0);
    check("rst2_stb", 32'(bus_if.wbm_stb_o), 0);
    check("rst2_rx_ready", 32'(bus_if.rx_ready), 0);
    exp_bus.delete();
    exp_tx.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst2_rx_ready_after", 32'(bus_if.rx_ready), 1);
    tx_stall = 0;
    repeat (40) @(negedge clk);
    check("rst2_quiet_busy", 32'(bus_if.busy), 0);

    run_txn(1'b1, 32'h3000_001C, 32'hFEED_FACE, 1);
    slave_rdata = 32'h89AB_CDEF;
    run_txn(1'b0, 32'h3000_001C, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

Wishbone master bridge driven by a UART byte stream: it turns byte-level command frames from the UART receive path into 32-bit Wishbone classic cycles on the user-project bus. Response bytes go back through the UART transmit path. It is the initiator counterpart of the UART CSR responder: a host on the serial line can read and write any Wishbone slave, including the UART's own CSRs at 0x3000_00xx. It sits between the uart_receive/uart_transmission byte interfaces and the Wishbone interconnect.

## Interface
- BUS_TIMEOUT, 1024: cycles to wait for wbm_ack_i before aborting a bus cycle (≥2).
- RX_TIMEOUT, 100000: idle cycles allowed between bytes of one frame before the partial frame is discarded (≥2).
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; held until accepted.
- rx_ready  out  1  bridge accepts rx_data this cycle when rx_valid & rx_ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle/strobe, always asserted together.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  constant 4'hF during a cycle, 4'h0 otherwise.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data, sampled with wbm_ack_i.
- wbm_ack_i  in  1  cycle termination.
- busy  out  1  high in any state other than IDLE.

## Operation
- Frames, multi-byte fields MSB first:
  - Write: 0x57, A3..A0, D3..D0.
  - Read: 0x52, A3..A0.
- Responses:
  - Write OK: 0x06.
  - Read OK: D3..D0.
  - Any bus timeout: 0x15.
- Any other byte received in IDLE is consumed and dropped with no response.
- States:
  - IDLE: rx_ready=1. On 0x57/0x52, latch the write flag and go to ADDR.
  - ADDR: rx_ready=1. Shift 4 bytes into the address register; the 2-bit counter wraps 3→0. After the 4th byte: write → DATA, read → BUS.
  - DATA: rx_ready=1. Shift 4 bytes into the data register, then go to BUS.
  - BUS: rx_ready=0. Assert cyc/stb/sel/we with the registered adr/dat. On ack: capture wbm_dat_i for reads and go to RESP. On timeout: drop cyc/stb, load 0x15 and go to RESP.
  - RESP: rx_ready=0. Present 1 byte (write or error) or 4 bytes (read) on tx. After the last handshake, go to IDLE.
- RX_TIMEOUT applies in ADDR/DATA only:
  - The counter clears on each accepted byte.
  - On expiry, discard the frame and go to IDLE with no response.
- Precedence when events coincide:
  - ack in the same cycle the bus timer expires: ack wins.
  - Byte accepted in the same cycle RX_TIMEOUT expires: the byte wins.
- wbm_ack_i outside BUS is ignored.
- rx_valid while rx_ready=0 stays pending upstream.

## Timing
- Reset values: all outputs 0, except rx_ready=1 after reset deassertion (0 while wb_rst_i=1). State is IDLE, all registers 0.
- Reset asserted mid-frame or mid-cycle:
  - cyc/stb/tx_valid drop immediately (asynchronously).
  - No response is emitted afterwards.
- Bus cycle start: cyc/stb rise on the first clock edge after the last frame byte is accepted.
- Bus cycle end:
  - Both fall on the edge where ack is sampled high.
  - Single-cycle ack gives a 1-cycle strobe.
  - Timeout: strobe lasts exactly BUS_TIMEOUT cycles.
- tx_valid rises on the edge after the BUS exit. Each following byte is presented on the edge after the previous tx handshake.
- rx_ready rises on the edge after the final tx handshake.
- Latency with immediate ack and tx_ready tied high:
  - Write: last byte → cyc 1 cycle → tx_valid 2 cycles → IDLE 3 cycles.
  - Read: IDLE after 6 cycles.

## Structure
- Package uart_bridge_pkg holds:
  - command constants CMD_WRITE=8'h57, CMD_READ=8'h52;
  - response constants RSP_OK=8'h06, RSP_ERR=8'h15;
  - the state enum {IDLE, ADDR, DATA, BUS, RESP}.
- One sub-module, bridge_timer: a loadable down-counter with an expiry flag, instantiated twice (RX_TIMEOUT and BUS_TIMEOUT).

## Test plan
- Write 57 30 00 00 04 DE AD BE EF, slave acks after 2 cycles → exactly one cycle with adr=0x3000_0004, dat=0xDEADBEEF, we=1, sel=F; tx emits 0x06.
- Read 52 30 00 00 00, slave returns 0x01C9C380 → tx emits 01 C9 C3 80 in order, with tx_ready stalled 5 cycles per byte and data held stable.
- Read with no ack → stb high exactly BUS_TIMEOUT cycles; tx emits 0x15; a following valid write succeeds.
- Byte 0x41 in IDLE, then 57 and 2 address bytes followed by RX_TIMEOUT idle cycles → no bus cycle, no tx output, busy returns to 0.
- ack in the same cycle as bus-timer expiry → treated as success: 0x06 for a write, captured data for a read.
- wb_rst_i pulsed while stb high and again while tx_valid high → outputs 0 at once; after release rx_ready=1 and a new frame completes normally.
